// File: rtl/note_pkg.sv
// note_pkg: constants and helpers shared by the note-to-PWM audio path.
//   NUM_NOTES / NOTE_NONE : seven notes C4..B4, index 7 means "no note"
//   PWM_MID               : DC midpoint level for an 8-bit PWM
//   HP_TABLE              : half-period of each note in 100 MHz cycles
//   lowest_set_idx()      : priority select, lowest set request bit wins
package note_pkg;

  localparam int         NUM_NOTES = 7;
  localparam logic [2:0] NOTE_NONE = 3'd7;
  localparam logic [7:0] PWM_MID   = 8'd128;
  localparam int         HP_W      = 18;

  // Packed so it can be passed straight through a module parameter; [0] = C4.
  localparam logic [NUM_NOTES-1:0][HP_W-1:0] HP_TABLE = {
    18'd101239,  // B4
    18'd113636,  // A4
    18'd127551,  // G4
    18'd143172,  // F4
    18'd151686,  // E4
    18'd170265,  // D4
    18'd191110   // C4
  };

  function automatic logic [2:0] lowest_set_idx(input logic [NUM_NOTES-1:0] req);
    lowest_set_idx = NOTE_NONE;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = NUM_NOTES - 1; i >= 0; i--)
      if (req[i]) lowest_set_idx = 3'(i);
  endfunction

endpackage

// File: rtl/note_tone_pwm_dac.sv
// pwm_dac: free-running PWM generator with frame-synchronous duty update.
//   clk_100mhz, reset : clock, synchronous active-high reset
//   enable            : 0 holds everything at its reset value
//   level             : requested duty, sampled only at the frame boundary
//   pwm_out           : registered PWM bit, high while counter < duty
//   frame_tick        : one-cycle pulse after the counter's last value
module pwm_dac
  import note_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_100mhz,
  input  logic                reset,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] level,
  output logic                pwm_out,
  output logic                frame_tick
);

  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(PWM_MID);

  logic [PWM_BITS-1:0] cnt_q, duty_q;
  logic                pwm_q, tick_q;
  logic                wrap;

  assign wrap = &cnt_q;

  always_ff @(posedge clk_100mhz) begin
    if (reset || !enable) begin
      cnt_q  <= '0;
      duty_q <= MID;
      pwm_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + PWM_BITS'(1);
      // Duty only moves at the frame boundary so a frame is never split.
      if (wrap) duty_q <= level;
      tick_q <= wrap;
      pwm_q  <= (cnt_q < duty_q);
    end
  end

  assign pwm_out    = pwm_q;
  assign frame_tick = tick_q;

endmodule

// File: rtl/note_tone_pwm.sv
// note_tone_pwm: turns the active note request into a square-wave tone and
// drives the mono PWM audio pin.
//   clk_100mhz, reset : 100 MHz clock, synchronous active-high reset
//   enable            : amp on / tone generation active
//   note_in           : note request bits C4..B4, lowest set bit wins
//   volume            : amplitude step 0..7
//   aud_pwm, aud_sd   : PWM audio bit, amplifier shutdown-not
//   playing, note_idx : tone status and current note (7 = none)
//   frame_tick        : pulse at each PWM frame boundary
module note_tone_pwm
  import note_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int HP_BITS   = 18,
  parameter int VOL_SHIFT = 4,
  parameter logic [NUM_NOTES-1:0][HP_BITS-1:0] HP_TAB = HP_TABLE
) (
  input  logic                 clk_100mhz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_NOTES-1:0] note_in,
  input  logic [2:0]           volume,
  output logic                 aud_pwm,
  output logic                 aud_sd,
  output logic                 playing,
  output logic [2:0]           note_idx,
  output logic                 frame_tick
);

  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(PWM_MID);

  logic [2:0]          sel;
  logic [2:0]          note_idx_q, hp_idx;
  logic                playing_q, aud_sd_q;
  logic [HP_BITS-1:0]  hp_cnt_q, hp_cnt_d, hp_last;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] amp, level;

  assign sel = lowest_set_idx(note_in);

  // Keep the table index in range when no note is active.
  assign hp_idx  = (note_idx_q == NOTE_NONE) ? 3'd0 : note_idx_q;
  assign hp_last = HP_TAB[hp_idx] - HP_BITS'(1);

  always_comb begin
    hp_cnt_d = hp_cnt_q + HP_BITS'(1);
    phase_d  = phase_q;
    if (sel != note_idx_q) begin
      // New note: restart in the high half.
      hp_cnt_d = '0;
      phase_d  = 1'b1;
    end else if (note_idx_q == NOTE_NONE) begin
      hp_cnt_d = '0;
    end else if (hp_cnt_q == hp_last) begin
      hp_cnt_d = '0;
      phase_d  = ~phase_q;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset || !enable) begin
      note_idx_q <= NOTE_NONE;
      playing_q  <= 1'b0;
      aud_sd_q   <= 1'b0;
      hp_cnt_q   <= '0;
      phase_q    <= 1'b1;
    end else begin
      note_idx_q <= sel;
      playing_q  <= (sel != NOTE_NONE);
      aud_sd_q   <= 1'b1;
      hp_cnt_q   <= hp_cnt_d;
      phase_q    <= phase_d;
    end
  end

  // Square wave swings symmetrically about the midpoint; silence sits at the
  // midpoint so starting and stopping a note does not click.
  assign amp   = PWM_BITS'(volume) << VOL_SHIFT;
  assign level = (note_idx_q == NOTE_NONE) ? MID :
                 phase_q                   ? MID + amp : MID - amp;

  pwm_dac #(.PWM_BITS(PWM_BITS)) u_dac (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .enable     (enable),
    .level      (level),
    .pwm_out    (aud_pwm),
    .frame_tick (frame_tick)
  );

  assign aud_sd   = aud_sd_q;
  assign playing  = playing_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_note_tone_pwm.sv
module tb_note_tone_pwm;
  import note_pkg::*;

  // Shortened half-periods keep tone-toggle checks inside a short run.
  localparam logic [NUM_NOTES-1:0][17:0] TB_HP = {
    18'd1581, 18'd1775, 18'd1993, 18'd2237, 18'd2370, 18'd2660, 18'd2986};
  int hp_exp  [7] = '{2986, 2660, 2370, 2237, 1993, 1775, 1581};
  int spec_hp [7] = '{191110, 170265, 151686, 143172, 127551, 113636, 101239};

  logic       clk_100mhz = 1'b0;
  logic       reset = 1'b1, enable = 1'b0;
  logic [6:0] note_in = '0;
  logic [2:0] volume = '0;
  logic       aud_pwm, aud_sd, playing, frame_tick;
  logic [2:0] note_idx;

  note_tone_pwm #(.HP_TAB(TB_HP)) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .enable     (enable),
    .note_in    (note_in),
    .volume     (volume),
    .aud_pwm    (aud_pwm),
    .aud_sd     (aud_sd),
    .playing    (playing),
    .note_idx   (note_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [6:0] note;
    logic       exp_play;
    logic [2:0] exp_idx;
    logic       exp_sd;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  function automatic int rst_vec();
    return int'({aud_pwm, aud_sd, playing, frame_tick, note_idx});
  endfunction

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    step();
    while (frame_tick !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 0, 1);
  endtask

  // Call on a frame_tick sample; counts the highs of the following frame.
  task automatic frame_highs(input string name, input int exp);
    int hi, tk;
    hi = 0;
    tk = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      hi += int'(aud_pwm);
      if (i < 255) tk += int'(frame_tick);
    end
    chk(name, hi, exp);
    chk({name, "_tick"}, int'(tk == 0 && frame_tick == 1'b1), 1);
  endtask

  task automatic wait_phase(input string name, input logic want, input int start,
                            input int gap, output int at);
    int n;
    n = 0;
    while (dut.phase_q !== want && n < 4000) begin
      step();
      n++;
    end
    at = cyc;
    chk(name, cyc - start, gap);
  endtask

  initial begin
    int c0, t1, t2, ca, ta, cb, tb, tc, cr, held;

    for (int i = 0; i < 7; i++)
      chk($sformatf("hp_table_%0d", i), int'(HP_TABLE[i]), spec_hp[i]);

    // Reset, then disabled: everything held at reset values.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_state", rst_vec(), 7);
    end
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      chk("disabled_state", rst_vec(), 7);
    end

    // Note select / status vectors.
    vt[0] = '{1'b0, 1'b1, 7'b0000001, 1'b1, 3'd0, 1'b1};
    vt[1] = '{1'b0, 1'b1, 7'b0100100, 1'b1, 3'd2, 1'b1};
    vt[2] = '{1'b0, 1'b1, 7'b1000000, 1'b1, 3'd6, 1'b1};
    vt[3] = '{1'b0, 1'b1, 7'b1111111, 1'b1, 3'd0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 7'b0110000, 1'b1, 3'd4, 1'b1};
    vt[5] = '{1'b0, 1'b1, 7'b0001000, 1'b1, 3'd3, 1'b1};
    vt[6] = '{1'b0, 1'b1, 7'b0000010, 1'b1, 3'd1, 1'b1};
    vt[7] = '{1'b0, 1'b1, 7'b0000000, 1'b0, 3'd7, 1'b1};
    vt[8] = '{1'b0, 1'b0, 7'b0010000, 1'b0, 3'd7, 1'b0};
    vt[9] = '{1'b1, 1'b1, 7'b0010000, 1'b0, 3'd7, 1'b0};
    for (int i = 0; i < 10; i++) begin
      reset   = vt[i].rst;
      enable  = vt[i].en;
      note_in = vt[i].note;
      step();
      chk($sformatf("vec%0d_playing", i), int'(playing), int'(vt[i].exp_play));
      chk($sformatf("vec%0d_idx", i), int'(note_idx), int'(vt[i].exp_idx));
      chk($sformatf("vec%0d_sd", i), int'(aud_sd), int'(vt[i].exp_sd));
      if (vt[i].rst || !vt[i].en)
        chk($sformatf("vec%0d_quiet", i), int'({aud_pwm, frame_tick}), 0);
    end

    // C4 at full volume from a fresh start.
    reset   = 1'b0;
    enable  = 1'b1;
    note_in = 7'b0000001;
    volume  = 3'd7;
    step();
    c0 = cyc;
    chk("c4_playing", int'(playing), 1);
    chk("c4_idx", int'(note_idx), 0);
    chk("c4_sd", int'(aud_sd), 1);
    chk("c4_phase_start", int'(dut.phase_q), 1);
    wait_tick("c4_first");
    chk("c4_first_tick", cyc - c0, 255);
    frame_highs("c4_high", 240);
    wait_phase("c4_toggle_lo", 1'b0, c0, hp_exp[0], t1);
    wait_tick("c4_lo");
    frame_highs("c4_low", 16);
    wait_phase("c4_toggle_hi", 1'b1, t1, hp_exp[0], t2);

    // Silence sits at the midpoint.
    note_in = 7'b0000000;
    step();
    chk("sil_playing", int'(playing), 0);
    chk("sil_idx", int'(note_idx), 7);
    wait_tick("sil");
    chk("sil_duty", int'(dut.u_dac.duty_q), 128);
    frame_highs("sil_high", 128);

    // Volume steps in the high half: 128 + vol*16.
    for (int i = 0; i < 2; i++) begin
      note_in = 7'b0000001;
      volume  = (i == 0) ? 3'd3 : 3'd0;
      step();
      wait_tick("vol");
      frame_highs($sformatf("vol%0d_high", volume), (i == 0) ? 176 : 128);
    end

    // E4 chosen from a two-bit request.
    volume  = 3'd7;
    note_in = 7'b0100100;
    step();
    c0 = cyc;
    chk("e4_idx", int'(note_idx), 2);
    chk("e4_phase_start", int'(dut.phase_q), 1);
    wait_phase("e4_toggle", 1'b0, c0, hp_exp[2], t1);

    // A4 in its low half, then switch to B4 mid-frame.
    note_in = 7'b0100000;
    step();
    ca = cyc;
    chk("a4_idx", int'(note_idx), 5);
    wait_phase("a4_toggle", 1'b0, ca, hp_exp[5], ta);
    wait_tick("a4_lo");
    chk("a4_duty_lo", int'(dut.u_dac.duty_q), 16);
    for (int i = 0; i < 100; i++) step();
    chk("a4_hp_cnt", int'(dut.hp_cnt_q), cyc - ta);
    note_in = 7'b1000000;
    step();
    cb = cyc;
    chk("b4_hp_restart", int'(dut.hp_cnt_q), 0);
    chk("b4_phase_start", int'(dut.phase_q), 1);
    chk("b4_idx", int'(note_idx), 6);
    held = 1;
    for (int n = 0; n < 300 && frame_tick !== 1'b1; n++) begin
      if (dut.u_dac.duty_q !== 8'd16) held = 0;
      step();
    end
    chk("b4_duty_held", held, 1);
    chk("b4_duty_new", int'(dut.u_dac.duty_q), 240);
    frame_highs("b4_high", 240);
    wait_phase("b4_toggle", 1'b0, cb, hp_exp[6], tb);

    // Reset in the middle of a loud high half.
    wait_phase("b4_toggle_hi", 1'b1, tb, hp_exp[6], tc);
    wait_tick("b4_hi");
    chk("pre_rst_duty", int'(dut.u_dac.duty_q), 240);
    reset = 1'b1;
    step();
    chk("midrst_state", rst_vec(), 7);
    chk("midrst_duty", int'(dut.u_dac.duty_q), 128);
    chk("midrst_hp", int'(dut.hp_cnt_q), 0);
    chk("midrst_phase", int'(dut.phase_q), 1);
    step();
    step();
    reset = 1'b0;
    step();
    cr = cyc;
    chk("post_rst_idx", int'(note_idx), 6);
    chk("post_rst_playing", int'(playing), 1);
    chk("post_rst_phase", int'(dut.phase_q), 1);
    chk("post_rst_hp", int'(dut.hp_cnt_q), 0);
    wait_tick("post_rst");
    chk("post_rst_first_tick", cyc - cr, 255);
    frame_highs("post_rst_high", 240);
    wait_phase("post_rst_toggle", 1'b0, cr, hp_exp[6], t1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
